// File: rtl/intersection_controller.sv
// Four-way intersection lamp sequencer with an optional pedestrian walk phase.
// The walk phase is built only when PED_CROSSING_EN is defined.
module intersection_controller #(
  parameter int GREEN_CYCLES   = 10,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_req,
  output logic ped_ack,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    CLEAR_A,
    EW_GREEN,
    EW_YELLOW,
    CLEAR_B,
    WALK
  } state_t;

  localparam logic [15:0] GREEN_LAST  = 16'(GREEN_CYCLES - 1);
  localparam logic [15:0] YELLOW_LAST = 16'(YELLOW_CYCLES - 1);
  localparam logic [15:0] CLEAR_LAST  = 16'(ALL_RED_CYCLES - 1);
  localparam logic [15:0] WALK_LAST   = 16'(WALK_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        last;
  logic        ped_go;
  logic        owed_ew_go;

  function automatic logic [15:0] phase_last(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return GREEN_LAST;
      NS_YELLOW, EW_YELLOW: return YELLOW_LAST;
      CLEAR_A, CLEAR_B:     return CLEAR_LAST;
      default:              return WALK_LAST;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NS_GREEN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PED_CROSSING_EN
  logic ped_pending;
  logic owed_ew;

  // Requests seen during WALK are dropped; the pending flag empties while walking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      owed_ew     <= 1'b0;
    end else begin
      if (state == WALK)
        ped_pending <= 1'b0;
      else if (ped_req)
        ped_pending <= 1'b1;
      if (last && state == CLEAR_A)
        owed_ew <= 1'b1;
      else if (last && state == CLEAR_B)
        owed_ew <= 1'b0;
    end
  end

  assign ped_go     = ped_pending;
  assign owed_ew_go = owed_ew;
  assign walk       = (state == WALK);
  assign ped_ack    = (state == WALK) && (cnt == '0);
`else
  logic ped_req_unused;
  assign ped_req_unused = ped_req;
  assign ped_go         = 1'b0;
  assign owed_ew_go     = 1'b0;
  assign walk           = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    last      = (cnt == phase_last(state));
    if (last) begin
      cnt_nxt = '0;
      case (state)
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: state_nxt = CLEAR_A;
        CLEAR_A:   state_nxt = ped_go ? WALK : EW_GREEN;
        EW_GREEN:  state_nxt = EW_YELLOW;
        EW_YELLOW: state_nxt = CLEAR_B;
        CLEAR_B:   state_nxt = ped_go ? WALK : NS_GREEN;
        WALK:      state_nxt = owed_ew_go ? EW_GREEN : NS_GREEN;
        default:   state_nxt = NS_GREEN;
      endcase
    end
  end

  // Lamps are a pure decode of the registered state.
  always_comb begin
    ns_green  = (state == NS_GREEN);
    ns_yellow = (state == NS_YELLOW);
    ew_green  = (state == EW_GREEN);
    ew_yellow = (state == EW_YELLOW);
    ns_red    = !(ns_green || ns_yellow);
    ew_red    = !(ew_green || ew_yellow);
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Randomised and directed bench for intersection_controller against a phase-table model.
module tb_intersection_controller;

  localparam int G = 10, Y = 3, C = 2, W = 6;
`ifdef PED_CROSSING_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req = 1'b0;
  logic ped_req1 = 1'b0;
  logic ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic ped_ack1, ns_red1, ns_yellow1, ns_green1, ew_red1, ew_yellow1, ew_green1, walk1;
  logic [7:0] dv, dv1;

  int tests = 0;
  int fails = 0;

  intersection_controller dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .ped_ack(ped_ack),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .walk(walk)
  );

  intersection_controller #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALL_RED_CYCLES(1), .WALK_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req1), .ped_ack(ped_ack1),
    .ns_red(ns_red1), .ns_yellow(ns_yellow1), .ns_green(ns_green1),
    .ew_red(ew_red1), .ew_yellow(ew_yellow1), .ew_green(ew_green1), .walk(walk1)
  );

  assign dv  = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack};
  assign dv1 = {ns_red1, ns_yellow1, ns_green1, ew_red1, ew_yellow1, ew_green1, walk1, ped_ack1};

  always #5 clk = ~clk;

  // Phases: 0 NS green, 1 NS yellow, 2 clear A, 3 EW green, 4 EW yellow, 5 clear B, 6 walk.
  typedef struct {
    int ph;
    int cnt;
    bit pend;
    int owed;
  } mstate_t;

  mstate_t m, m1;

  localparam logic [7:0] O_NSG  = 8'b0011_0000;
  localparam logic [7:0] O_EWG  = 8'b1000_0100;
  localparam logic [7:0] O_RED  = 8'b1001_0000;
  localparam logic [7:0] O_WALK = 8'b1001_0010;
  localparam logic [7:0] O_ACK  = 8'b1001_0011;

  function automatic mstate_t mreset();
    mstate_t r;
    r.ph = 0; r.cnt = 0; r.pend = 1'b0; r.owed = 3;
    return r;
  endfunction

  function automatic int dur(input int ph, input bit ones);
    if (ones) return 1;
    case (ph)
      0, 3:    return G;
      1, 4:    return Y;
      2, 5:    return C;
      default: return W;
    endcase
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit req, input bit ones);
    mstate_t n;
    n = s;
    if (PED) begin
      if (s.ph == 6) n.pend = 1'b0;
      else if (req) n.pend = 1'b1;
    end
    if (s.cnt + 1 < dur(s.ph, ones)) begin
      n.cnt = s.cnt + 1;
    end else begin
      n.cnt = 0;
      if (s.ph == 2 && PED && s.pend) begin n.ph = 6; n.owed = 3; end
      else if (s.ph == 5 && PED && s.pend) begin n.ph = 6; n.owed = 0; end
      else if (s.ph == 5) n.ph = 0;
      else if (s.ph == 6) n.ph = s.owed;
      else n.ph = s.ph + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] model_out(input mstate_t s);
    logic ng, ny, eg, ey, w;
    ng = (s.ph == 0); ny = (s.ph == 1);
    eg = (s.ph == 3); ey = (s.ph == 4);
    w  = (s.ph == 6);
    return {!(ng || ny), ny, ng, !(eg || ey), ey, eg, w, w && (s.cnt == 0)};
  endfunction

  task automatic clk_step(input bit req);
    ped_req = req;
    @(posedge clk);
    if (rst_n) begin
      m  = mstep(m, req, 1'b0);
      m1 = mstep(m1, 1'b0, 1'b1);
    end else begin
      m  = mreset();
      m1 = mreset();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ped_req = 1'b0;
    m = mreset();
    m1 = mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m = mreset();
    m1 = mreset();
    for (int i = 0; i < 4; i++) begin
      clk_step(1'b1);
      tests++;
      if (dv !== O_NSG) begin
        fails++;
        $display("FAIL reset_lamps%0d got %b want %b", i, dv, O_NSG);
      end
      tests++;
      if (dv1 !== O_NSG) begin
        fails++;
        $display("FAIL reset_lamps_p1_%0d got %b want %b", i, dv1, O_NSG);
      end
    end
    ped_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_no_request();
    logic [7:0] obs [0:64];
    int ng, ny, eg, ey, br, per_bad;
    do_reset();
    for (int i = 0; i <= 64; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL norq_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      obs[i] = dv;
      clk_step(1'b0);
    end
    ng = 0; ny = 0; eg = 0; ey = 0; br = 0; per_bad = 0;
    for (int i = 0; i < 30; i++) begin
      ng += int'(obs[i][5]);
      ny += int'(obs[i][6]);
      eg += int'(obs[i][2]);
      ey += int'(obs[i][3]);
      br += int'(obs[i] == O_RED);
      if (obs[i] !== obs[i + 30]) per_bad++;
    end
    tests++;
    if (ng != G) begin fails++; $display("FAIL norq_ns_green got %0d want %0d", ng, G); end
    tests++;
    if (ny != Y) begin fails++; $display("FAIL norq_ns_yellow got %0d want %0d", ny, Y); end
    tests++;
    if (eg != G) begin fails++; $display("FAIL norq_ew_green got %0d want %0d", eg, G); end
    tests++;
    if (ey != Y) begin fails++; $display("FAIL norq_ew_yellow got %0d want %0d", ey, Y); end
    tests++;
    if (br != 2 * C) begin fails++; $display("FAIL norq_all_red got %0d want %0d", br, 2 * C); end
    tests++;
    if (obs[13] !== O_RED || obs[15] !== O_EWG) begin
      fails++;
      $display("FAIL norq_order got %b,%b want %b,%b", obs[13], obs[15], O_RED, O_EWG);
    end
    tests++;
    if (per_bad != 0) begin fails++; $display("FAIL norq_period30 got %0d differing want 0", per_bad); end
  endtask

`ifdef PED_CROSSING_EN
  task automatic test_request_service();
    logic [7:0] obs [0:39];
    int acks;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL svc_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      obs[i] = dv;
      clk_step(i == 3);
    end
    acks = 0;
    for (int i = 0; i < 40; i++) acks += int'(obs[i][0]);
    tests++;
    if (acks != 1) begin fails++; $display("FAIL svc_ack_count got %0d want 1", acks); end
    tests++;
    if (obs[14] !== O_RED || obs[15] !== O_ACK) begin
      fails++;
      $display("FAIL svc_walk_entry got %b,%b want %b,%b", obs[14], obs[15], O_RED, O_ACK);
    end
    for (int i = 16; i <= 20; i++) begin
      tests++;
      if (obs[i] !== O_WALK) begin fails++; $display("FAIL svc_walk%0d got %b want %b", i, obs[i], O_WALK); end
    end
    tests++;
    if (obs[21] !== O_EWG) begin fails++; $display("FAIL svc_after_walk got %b want %b", obs[21], O_EWG); end
  endtask

  task automatic test_boundary();
    logic [7:0] obs [0:40];
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL bnd_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      obs[i] = dv;
      clk_step(i == 14);
    end
    tests++;
    if (obs[15] !== O_EWG) begin fails++; $display("FAIL bnd_ew_follows got %b want %b", obs[15], O_EWG); end
    tests++;
    if (obs[29] !== O_RED || obs[30] !== O_ACK) begin
      fails++;
      $display("FAIL bnd_walk_after_b got %b,%b want %b,%b", obs[29], obs[30], O_RED, O_ACK);
    end
    tests++;
    if (obs[35] !== O_WALK || obs[36] !== O_NSG) begin
      fails++;
      $display("FAIL bnd_ns_after_walk got %b,%b want %b,%b", obs[35], obs[36], O_WALK, O_NSG);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs [0:45];
    int acks;
    do_reset();
    for (int i = 0; i <= 45; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL b2b_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      obs[i] = dv;
      clk_step(i >= 3 && i <= 21);
    end
    acks = 0;
    for (int i = 0; i <= 35; i++) acks += int'(obs[i][0]);
    tests++;
    if (acks != 1) begin fails++; $display("FAIL b2b_single_ack got %0d want 1", acks); end
    tests++;
    if (obs[21] !== O_EWG || obs[30] !== O_EWG) begin
      fails++;
      $display("FAIL b2b_green_kept got %b,%b want %b", obs[21], obs[30], O_EWG);
    end
    tests++;
    if (obs[35] !== O_RED || obs[36] !== O_ACK) begin
      fails++;
      $display("FAIL b2b_second_walk got %b,%b want %b,%b", obs[35], obs[36], O_RED, O_ACK);
    end
  endtask
`else
  task automatic test_ped_ignored();
    int walks;
    do_reset();
    walks = 0;
    for (int i = 0; i < 70; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL noped_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      walks += int'(walk) + int'(ped_ack);
      clk_step(1'b1);
    end
    tests++;
    if (walks != 0) begin fails++; $display("FAIL noped_walk_ack got %0d want 0", walks); end
  endtask
`endif

  task automatic test_reset_mid_phase();
    int walks;
    do_reset();
    for (int i = 0; i < 26; i++) clk_step(i == 16);
    tests++;
    if (dv !== 8'b1000_1000) begin fails++; $display("FAIL mid_in_ew_yellow got %b want %b", dv, 8'b1000_1000); end
    #2;
    rst_n = 1'b0;
    m = mreset();
    m1 = mreset();
    #1;
    tests++;
    if (dv !== O_NSG) begin fails++; $display("FAIL mid_async_reset got %b want %b", dv, O_NSG); end
    @(negedge clk);
    rst_n = 1'b1;
    walks = 0;
    for (int i = 0; i < 70; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL mid_after_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      walks += int'(walk);
      clk_step(1'b0);
    end
    tests++;
    if (walks != 0) begin fails++; $display("FAIL mid_no_walk got %0d want 0", walks); end
  endtask

  task automatic test_params_one();
    int ng, bad;
    do_reset();
    ng = 0; bad = 0;
    for (int i = 0; i < 24; i++) begin
      tests++;
      if (dv1 !== model_out(m1)) begin
        fails++;
        $display("FAIL one_cycle%0d got %b want %b", i, dv1, model_out(m1));
      end
      ng += int'(ns_green1);
      if (int'(ns_red1) + int'(ns_yellow1) + int'(ns_green1) != 1) bad++;
      if (int'(ew_red1) + int'(ew_yellow1) + int'(ew_green1) != 1) bad++;
      if ((ns_green1 || ns_yellow1) && (ew_green1 || ew_yellow1)) bad++;
      if (walk1 || ped_ack1) bad++;
      clk_step(1'b0);
    end
    tests++;
    if (ng != 4) begin fails++; $display("FAIL one_period6 got %0d ns greens want 4", ng); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL one_exclusion got %0d violations want 0", bad); end
  endtask

  task automatic test_random();
    bit req;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      tests++;
      if (dv !== model_out(m)) begin
        fails++;
        $display("FAIL rnd_cycle%0d got %b want %b", i, dv, model_out(m));
      end
      if ((ns_green || ns_yellow) && (ew_green || ew_yellow)) bad++;
      if (walk && !(ns_red && ew_red)) bad++;
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        m = mreset();
        m1 = mreset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        req = ($urandom_range(0, 11) == 0);
        clk_step(req);
      end
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rnd_exclusion got %0d violations want 0", bad); end
  endtask

  initial begin
    m = mreset();
    m1 = mreset();
    test_reset();
    test_no_request();
`ifdef PED_CROSSING_EN
    test_request_service();
    test_boundary();
    test_back_to_back();
`else
    test_ped_ignored();
`endif
    test_reset_mid_phase();
    test_params_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
